intra_chroma8x8_modesel: RTL and testbench



---
 rtl/intra_chroma8x8_modesel.sv | 206 ++++++++++++++++++++
 tb/tb_intra_chroma8x8_modesel.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intra_chroma8x8_modesel.sv
// Chroma 8x8 intra mode decision: DC / horizontal / vertical SAD evaluation,
// one row of eight absolute differences per cycle, best-mode selection and
// prediction block output.
module intra_chroma8x8_modesel (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0][7:0] mb,
    input  logic [7:0][7:0]  toppixels,
    input  logic [7:0][7:0]  leftpixels,
    input  logic             top_avail,
    input  logic             left_avail,
    output logic             busy,
    output logic             done,
    output logic [1:0]       best_mode,
    output logic [13:0]      best_sad,
    output logic [63:0][7:0] pred
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DCCALC = 2'd1;
    localparam logic [1:0] S_EVAL   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [4:0] LAST_STEP = 5'd23;

    logic [1:0]             state_q, state_d;
    logic [4:0]             cnt_q;
    logic [63:0][7:0]       mb_q;
    logic [7:0][7:0]        top_q;
    logic [7:0][7:0]        left_q;
    logic                   tav_q, lav_q;
    logic [3:0][7:0]        dc_q, dc_d;      // index {qy, qx}
    logic [13:0]            sad_dc_q, sad_h_q, sad_v_q;
    logic                   done_q;
    logic [1:0]             mode_q;
    logic [13:0]            bsad_q;
    logic [63:0][7:0]       pred_q;

    logic [9:0]             t0, t1, l0, l1;
    logic [10:0]            row_sum;
    logic [1:0]             sel_mode;
    logic [13:0]            sel_sad;
    logic [63:0][7:0]       sel_pred;

    // (s + 2) >> 2 for a sum of four pixels
    function automatic logic [7:0] avg4(input logic [9:0] s);
        logic [10:0] t;
        t = {1'b0, s} + 11'd2;
        return t[9:2];
    endfunction

    // (a + b + 4) >> 3 for two sums of four pixels
    function automatic logic [7:0] avg8(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] t;
        t = {1'b0, a} + {1'b0, b} + 11'd4;
        return t[10:3];
    endfunction

    // Diagonal quadrants use both neighbours when they can
    function automatic logic [7:0] dc_diag(input logic [9:0] t, input logic [9:0] l,
                                           input logic ta, input logic la);
        if (ta && la)  return avg8(t, l);
        else if (ta)   return avg4(t);
        else if (la)   return avg4(l);
        else           return 8'd128;
    endfunction

    // Off-diagonal quadrants use a single neighbour, preferred side first
    function automatic logic [7:0] dc_pref(input logic [9:0] first, input logic [9:0] second,
                                           input logic fa, input logic sa);
        if (fa)        return avg4(first);
        else if (sa)   return avg4(second);
        else           return 8'd128;
    endfunction

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign best_mode = mode_q;
    assign best_sad  = bsad_q;
    assign pred      = pred_q;

    // Next-state logic for the mode-decision sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_DCCALC;
            S_DCCALC: state_d = S_EVAL;
            S_EVAL:   if (cnt_q == LAST_STEP) state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Quadrant DC values from the latched neighbours
    always_comb begin
        t0 = {2'b0, top_q[0]} + {2'b0, top_q[1]} + {2'b0, top_q[2]} + {2'b0, top_q[3]};
        t1 = {2'b0, top_q[4]} + {2'b0, top_q[5]} + {2'b0, top_q[6]} + {2'b0, top_q[7]};
        l0 = {2'b0, left_q[0]} + {2'b0, left_q[1]} + {2'b0, left_q[2]} + {2'b0, left_q[3]};
        l1 = {2'b0, left_q[4]} + {2'b0, left_q[5]} + {2'b0, left_q[6]} + {2'b0, left_q[7]};
        dc_d[0] = dc_diag(t0, l0, tav_q, lav_q);   // qy=0, qx=0
        dc_d[1] = dc_pref(t1, l0, tav_q, lav_q);   // qy=0, qx=1: top preferred
        dc_d[2] = dc_pref(l1, t0, lav_q, tav_q);   // qy=1, qx=0: left preferred
        dc_d[3] = dc_diag(t1, l1, tav_q, lav_q);   // qy=1, qx=1
    end

    // SAD of the row selected by the step counter under the current mode
    always_comb begin
        logic [2:0] row;
        logic [2:0] xb;
        logic [7:0] p;
        logic [7:0] s;
        logic [7:0] ad;
        row     = cnt_q[2:0];
        row_sum = 11'd0;
        for (int x = 0; x < 8; x++) begin
            xb = 3'(x);
            case (cnt_q[4:3])
                2'd0:    p = dc_q[{row[2], xb[2]}];
                2'd1:    p = left_q[row];
                default: p = top_q[xb];
            endcase
            s  = mb_q[{row, xb}];
            ad = (s > p) ? (s - p) : (p - s);
            row_sum = row_sum + {3'b0, ad};
        end
    end

    // Lowest-cost candidate; strict compares let ties keep the lower mode
    always_comb begin
        logic [5:0] ib;
        sel_mode = 2'd0;
        sel_sad  = sad_dc_q;
        if (lav_q && (sad_h_q < sel_sad)) begin
            sel_mode = 2'd1;
            sel_sad  = sad_h_q;
        end
        if (tav_q && (sad_v_q < sel_sad)) begin
            sel_mode = 2'd2;
            sel_sad  = sad_v_q;
        end
        for (int i = 0; i < 64; i++) begin
            ib = 6'(i);
            case (sel_mode)
                2'd0:    sel_pred[i] = dc_q[{ib[5], ib[2]}];
                2'd1:    sel_pred[i] = left_q[ib[5:3]];
                default: sel_pred[i] = top_q[ib[2:0]];
            endcase
        end
    end

    // Sequencer state, input capture, DC registers, SAD accumulation, results
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            mb_q     <= '0;
            top_q    <= '0;
            left_q   <= '0;
            tav_q    <= 1'b0;
            lav_q    <= 1'b0;
            dc_q     <= '0;
            sad_dc_q <= 14'd0;
            sad_h_q  <= 14'd0;
            sad_v_q  <= 14'd0;
            done_q   <= 1'b0;
            mode_q   <= 2'd0;
            bsad_q   <= 14'd0;
            pred_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mb_q     <= mb;
                        top_q    <= toppixels;
                        left_q   <= leftpixels;
                        tav_q    <= top_avail;
                        lav_q    <= left_avail;
                        cnt_q    <= 5'd0;
                        sad_dc_q <= 14'd0;
                        sad_h_q  <= 14'd0;
                        sad_v_q  <= 14'd0;
                    end
                end
                S_DCCALC: begin
                    dc_q <= dc_d;
                end
                S_EVAL: begin
                    cnt_q <= cnt_q + 5'd1;
                    case (cnt_q[4:3])
                        2'd0:    sad_dc_q <= sad_dc_q + {3'b0, row_sum};
                        2'd1:    sad_h_q  <= sad_h_q + {3'b0, row_sum};
                        default: sad_v_q  <= sad_v_q + {3'b0, row_sum};
                    endcase
                end
                default: begin
                    mode_q <= sel_mode;
                    bsad_q <= sel_sad;
                    pred_q <= sel_pred;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intra_chroma8x8_modesel.sv
// Bench for intra_chroma8x8_modesel: directed mode cases, randomized blocks
// against a whole-block reference model, busy/abort/back-to-back behaviour.
module tb_intra_chroma8x8_modesel;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [63:0][7:0] d_mb;
    logic [7:0][7:0]  d_top, d_left;
    logic             d_ta, d_la;
    logic             busy, done;
    logic [1:0]       best_mode;
    logic [13:0]      best_sad;
    logic [63:0][7:0] pred;

    int total = 0;
    int bad   = 0;

    // Stimulus as intended for the current operation
    logic [63:0][7:0] s_mb;
    logic [7:0][7:0]  s_top, s_left;
    logic             s_ta, s_la;

    // Observed results of do_op
    int               lat;
    logic             busy_e0, busy_end;
    logic [1:0]       o_mode;
    logic [13:0]      o_sad;
    logic [63:0][7:0] o_pred;

    // Reference model results
    logic [1:0]       e_mode;
    logic [13:0]      e_sad;
    logic [63:0][7:0] e_pred;

    intra_chroma8x8_modesel dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mb         (d_mb),
        .toppixels  (d_top),
        .leftpixels (d_left),
        .top_avail  (d_ta),
        .left_avail (d_la),
        .busy       (busy),
        .done       (done),
        .best_mode  (best_mode),
        .best_sad   (best_sad),
        .pred       (pred)
    );

    always #5 clk = ~clk;

    task automatic scramble();
        d_mb   = {16{$urandom()}};
        d_top  = {$urandom(), $urandom()};
        d_left = {$urandom(), $urandom()};
        d_ta   = 1'($urandom_range(0, 1));
        d_la   = 1'($urandom_range(0, 1));
    endtask

    // Whole-block reference: quadrant DCs, three full SADs, gated selection
    task automatic model();
        int dc[4];
        int sad[3];
        int p[3];
        int tsum, lsum, v, d, bm;
        for (int qy = 0; qy < 2; qy++) begin
            for (int qx = 0; qx < 2; qx++) begin
                tsum = 0;
                lsum = 0;
                for (int i = 0; i < 4; i++) begin
                    tsum += int'(s_top[qx*4+i]);
                    lsum += int'(s_left[qy*4+i]);
                end
                if (qx == qy) begin
                    if (s_ta && s_la) v = (tsum + lsum + 4) / 8;
                    else if (s_ta)    v = (tsum + 2) / 4;
                    else if (s_la)    v = (lsum + 2) / 4;
                    else              v = 128;
                end else if (qx == 1) begin
                    if (s_ta)         v = (tsum + 2) / 4;
                    else if (s_la)    v = (lsum + 2) / 4;
                    else              v = 128;
                end else begin
                    if (s_la)         v = (lsum + 2) / 4;
                    else if (s_ta)    v = (tsum + 2) / 4;
                    else              v = 128;
                end
                dc[qy*2+qx] = v;
            end
        end
        sad = '{0, 0, 0};
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                p[0] = dc[(y/4)*2 + x/4];
                p[1] = int'(s_left[y]);
                p[2] = int'(s_top[x]);
                for (int k = 0; k < 3; k++) begin
                    d = int'(s_mb[y*8+x]) - p[k];
                    sad[k] += (d < 0) ? -d : d;
                end
            end
        bm = 0;
        if (s_la && sad[1] < sad[bm]) bm = 1;
        if (s_ta && sad[2] < sad[bm]) bm = 2;
        e_mode = 2'(bm);
        e_sad  = 14'(sad[bm]);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                p[0] = dc[(y/4)*2 + x/4];
                p[1] = int'(s_left[y]);
                p[2] = int'(s_top[x]);
                e_pred[y*8+x] = 8'(p[bm]);
            end
    endtask

    task automatic rand_stim();
        int pat, base, v;
        s_ta   = 1'($urandom_range(0, 1));
        s_la   = 1'($urandom_range(0, 1));
        s_top  = {$urandom(), $urandom()};
        s_left = {$urandom(), $urandom()};
        pat    = int'($urandom_range(0, 3));
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                case (pat)
                    0:       base = int'($urandom_range(0, 255));
                    1:       base = int'(s_left[y]);
                    2:       base = int'(s_top[x]);
                    default: base = 128;
                endcase
                v = base + int'($urandom_range(0, 8)) - 4;
                if (v < 0)   v = 0;
                if (v > 255) v = 255;
                s_mb[y*8+x] = 8'(v);
            end
    endtask

    // One operation: start sampled at E0, inputs scrambled afterwards, done awaited
    task automatic do_op();
        @(negedge clk);
        d_mb = s_mb; d_top = s_top; d_left = s_left; d_ta = s_ta; d_la = s_la;
        start = 1'b1;
        @(posedge clk);
        #1 busy_e0 = busy;
        @(negedge clk);
        start = 1'b0;
        scramble();
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        busy_end = busy;
        o_mode   = best_mode;
        o_sad    = best_sad;
        o_pred   = pred;
        model();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        d_mb = '0; d_top = '0; d_left = '0; d_ta = 1'b0; d_la = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
        total++; if (best_mode !== 2'd0)  begin bad++; $display("FAIL reset_mode: got %0d want 0", best_mode); end
        total++; if (best_sad !== 14'd0)  begin bad++; $display("FAIL reset_sad: got %0d want 0", best_sad); end
        total++; if (pred !== '0)         begin bad++; $display("FAIL reset_pred: got %h want 0", pred); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_dc_tie();
        logic [63:0][7:0] want;
        s_mb = {64{8'd100}}; s_top = {8{8'd100}}; s_left = {8{8'd100}};
        s_ta = 1'b1; s_la = 1'b1;
        want = {64{8'd100}};
        do_op();
        total++; if (busy_e0 !== 1'b1)  begin bad++; $display("FAIL dc_busy_rise: got %0b want 1", busy_e0); end
        total++; if (busy_end !== 1'b0) begin bad++; $display("FAIL dc_busy_fall: got %0b want 0", busy_end); end
        total++; if (lat != 26)         begin bad++; $display("FAIL dc_latency: got %0d want 26", lat); end
        total++; if (o_mode !== 2'd0)   begin bad++; $display("FAIL dc_mode: got %0d want 0", o_mode); end
        total++; if (o_sad !== 14'd0)   begin bad++; $display("FAIL dc_sad: got %0d want 0", o_sad); end
        total++; if (o_pred !== want)   begin bad++; $display("FAIL dc_pred: got %h want %h", o_pred, want); end
    endtask

    task automatic test_horizontal();
        logic [63:0][7:0] want;
        s_top = '0; s_ta = 1'b1; s_la = 1'b1;
        for (int y = 0; y < 8; y++) begin
            s_left[y] = 8'(10*y);
            for (int x = 0; x < 8; x++) begin
                s_mb[y*8+x] = 8'(10*y);
                want[y*8+x] = 8'(10*y);
            end
        end
        do_op();
        total++; if (lat != 26)        begin bad++; $display("FAIL h_latency: got %0d want 26", lat); end
        total++; if (o_mode !== 2'd1)  begin bad++; $display("FAIL h_mode: got %0d want 1", o_mode); end
        total++; if (o_sad !== 14'd0)  begin bad++; $display("FAIL h_sad: got %0d want 0", o_sad); end
        total++; if (o_pred !== want)  begin bad++; $display("FAIL h_pred: got %h want %h", o_pred, want); end
    endtask

    task automatic test_vertical();
        logic [63:0][7:0] want;
        s_left = {8{8'd255}}; s_ta = 1'b1; s_la = 1'b1;
        for (int x = 0; x < 8; x++) s_top[x] = 8'(20*x);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                s_mb[y*8+x] = 8'(20*x);
                want[y*8+x] = 8'(20*x);
            end
        do_op();
        total++; if (o_mode !== 2'd2)  begin bad++; $display("FAIL v_mode: got %0d want 2", o_mode); end
        total++; if (o_sad !== 14'd0)  begin bad++; $display("FAIL v_sad: got %0d want 0", o_sad); end
        total++; if (o_pred !== want)  begin bad++; $display("FAIL v_pred: got %h want %h", o_pred, want); end
    endtask

    task automatic test_no_avail();
        logic [63:0][7:0] want;
        want = {64{8'd128}};
        s_mb = '0; s_top = {$urandom(), $urandom()}; s_left = {$urandom(), $urandom()};
        s_ta = 1'b0; s_la = 1'b0;
        do_op();
        total++; if (lat != 26)          begin bad++; $display("FAIL na_latency: got %0d want 26", lat); end
        total++; if (o_mode !== 2'd0)    begin bad++; $display("FAIL na_mode: got %0d want 0", o_mode); end
        total++; if (o_sad !== 14'd8192) begin bad++; $display("FAIL na_sad: got %0d want 8192", o_sad); end
        total++; if (o_pred !== want)    begin bad++; $display("FAIL na_pred: got %h want %h", o_pred, want); end
        // Perfect horizontal match must still lose when nothing is available
        s_top = '0;
        for (int y = 0; y < 8; y++) begin
            s_left[y] = 8'(10*y);
            for (int x = 0; x < 8; x++) s_mb[y*8+x] = 8'(10*y);
        end
        do_op();
        total++; if (o_mode !== 2'd0)    begin bad++; $display("FAIL na_match_mode: got %0d want 0", o_mode); end
        total++; if (o_sad !== 14'd5952) begin bad++; $display("FAIL na_match_sad: got %0d want 5952", o_sad); end
        total++; if (o_pred !== want)    begin bad++; $display("FAIL na_match_pred: got %h want %h", o_pred, want); end
    endtask

    task automatic test_top_only();
        logic [63:0][7:0] want;
        s_mb = '0; s_left = {$urandom(), $urandom()};
        s_ta = 1'b1; s_la = 1'b0;
        for (int x = 0; x < 8; x++) s_top[x] = (x < 4) ? 8'd40 : 8'd80;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) want[y*8+x] = (x < 4) ? 8'd40 : 8'd80;
        do_op();
        total++; if (o_mode !== 2'd0)    begin bad++; $display("FAIL top_mode: got %0d want 0", o_mode); end
        total++; if (o_sad !== 14'd3840) begin bad++; $display("FAIL top_sad: got %0d want 3840", o_sad); end
        total++; if (o_pred !== want)    begin bad++; $display("FAIL top_pred: got %h want %h", o_pred, want); end
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL done_pulse: got %0b want 0", done); end
        total++; if (best_sad !== 14'd3840) begin bad++; $display("FAIL sad_hold: got %0d want 3840", best_sad); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            rand_stim();
            do_op();
            total++; if (lat != 26)        begin bad++; $display("FAIL rnd%0d_latency: got %0d want 26", n, lat); end
            total++; if (o_mode !== e_mode) begin bad++; $display("FAIL rnd%0d_mode: got %0d want %0d", n, o_mode, e_mode); end
            total++; if (o_sad !== e_sad)   begin bad++; $display("FAIL rnd%0d_sad: got %0d want %0d", n, o_sad, e_sad); end
            total++; if (o_pred !== e_pred) begin bad++; $display("FAIL rnd%0d_pred: got %h want %h", n, o_pred, e_pred); end
        end
    endtask

    task automatic test_busy_ignore();
        int first, ndone;
        rand_stim();
        model();
        @(negedge clk);
        d_mb = s_mb; d_top = s_top; d_left = s_left; d_ta = s_ta; d_la = s_la;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        first = -1;
        ndone = 0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 5) begin
                start = 1'b1;
                scramble();
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first < 0) first = k;
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (ndone != 1)          begin bad++; $display("FAIL ignore_count: got %0d want 1", ndone); end
        total++; if (first != 26)         begin bad++; $display("FAIL ignore_latency: got %0d want 26", first); end
        total++; if (best_mode !== e_mode) begin bad++; $display("FAIL ignore_mode: got %0d want %0d", best_mode, e_mode); end
        total++; if (best_sad !== e_sad)   begin bad++; $display("FAIL ignore_sad: got %0d want %0d", best_sad, e_sad); end
    endtask

    task automatic test_abort_reset();
        int ndone;
        s_mb = {16{$urandom()}}; s_top = '0; s_left = '0; s_ta = 1'b1; s_la = 1'b1;
        s_mb[0] = 8'd200;
        do_op();
        rand_stim();
        @(negedge clk);
        d_mb = s_mb; d_top = s_top; d_left = s_left; d_ta = s_ta; d_la = s_la;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL abort_busy: got %0b want 0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL abort_done: got %0b want 0", done); end
        total++; if (best_mode !== 2'd0) begin bad++; $display("FAIL abort_mode: got %0d want 0", best_mode); end
        total++; if (best_sad !== 14'd0) begin bad++; $display("FAIL abort_sad: got %0d want 0", best_sad); end
        total++; if (pred !== '0)        begin bad++; $display("FAIL abort_pred: got %h want 0", pred); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", ndone); end
        rand_stim();
        do_op();
        total++; if (lat != 26)         begin bad++; $display("FAIL abort_restart_latency: got %0d want 26", lat); end
        total++; if (o_sad !== e_sad)   begin bad++; $display("FAIL abort_restart_sad: got %0d want %0d", o_sad, e_sad); end
        total++; if (o_pred !== e_pred) begin bad++; $display("FAIL abort_restart_pred: got %h want %h", o_pred, e_pred); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 2; n++) begin
            rand_stim();
            do_op();
            total++; if (lat != 26)         begin bad++; $display("FAIL b2b%0d_latency: got %0d want 26", n, lat); end
            total++; if (o_mode !== e_mode) begin bad++; $display("FAIL b2b%0d_mode: got %0d want %0d", n, o_mode, e_mode); end
            total++; if (o_sad !== e_sad)   begin bad++; $display("FAIL b2b%0d_sad: got %0d want %0d", n, o_sad, e_sad); end
            total++; if (o_pred !== e_pred) begin bad++; $display("FAIL b2b%0d_pred: got %h want %h", n, o_pred, e_pred); end
        end
    endtask

    initial begin
        test_reset();
        test_dc_tie();
        test_horizontal();
        test_vertical();
        test_no_avail();
        test_top_only();
        test_random();
        test_busy_ignore();
        test_abort_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
